mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Memory-side arbiter below top: merges top's instruction-cache refill port (iad/imreq/idt/acki_n)
//  and data-cache port (dad/dmreq/dmwrite/ddt/ackd_n) onto one external memory port.
//  One transaction in flight at a time. Grants alternate when both ports request.
//  A watchdog reports a memory that never acks.
// PARAMETERS
//  WORD_SIZE     32    address width
//  IMEMBUS_SIZE  256   I-side line width, bits
//  DMEMBUS_SIZE  256   D-side line and memory data width, bits; must be >= IMEMBUS_SIZE
//  TIMEOUT       1023  max cycles mreq may wait for mack_n; counter width is clog2(TIMEOUT+1)
// PORTS
//  clk      in     1             clock; all state changes on rising edge
//  rst      in     1             reset, asynchronous, active-low
//  iad      in     WORD_SIZE     I-side line address
//  imreq    in     1             I-side read request, level
//  idt      out    IMEMBUS_SIZE  I-side read data; valid while acki_n=0
//  acki_n   out    1             I-side completion, active-low, one-cycle pulse
//  dad      in     WORD_SIZE     D-side line address
//  dmreq    in     1             D-side request, level
//  dmwrite  in     1             D-side 1=write line, 0=read line
//  ddt      inout  DMEMBUS_SIZE  D-side data; write data in; driven only while ackd_n=0 on reads, else Z
//  ackd_n   out    1             D-side completion, active-low, one-cycle pulse
//  maddr    out    WORD_SIZE     memory address (registered)
//  mreq     out    1             memory request, held until mack_n=0 or timeout
//  mwrite   out    1             memory write enable, qualifies mreq
//  mwdata   out    DMEMBUS_SIZE  memory write data (registered)
//  mrdata   in     DMEMBUS_SIZE  memory read data; valid while mack_n=0
//  mack_n   in     1             memory completion, active-low, sampled only while mreq=1
//  timeout  out    1             sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset (rst=0, any state, async): state=IDLE. acki_n=ackd_n=1. mreq=mwrite=0, maddr=mwdata=0.
//   idt=0, ddt=Z, timeout=0, last_grant=I (D wins the first tie).
//   Any in-flight transaction is abandoned; no ack is issued for it.
//  Requester contract: req, addr, dmwrite and write data stay stable from req rise until the ack cycle.
//   The requester drops req in the cycle after ack.
//  FSM IDLE -> BUSY -> RESP -> TURN -> IDLE.
//  IDLE: sample imreq/dmreq.
//   Only one asserted: grant it. Both asserted: grant the port not in last_grant. Grant updates last_grant.
//   On grant: register maddr, mwrite (dmwrite for D, 0 for I), and mwdata=ddt on D-writes;
//    set mreq=1, go to BUSY, clear watchdog count. mreq rises the cycle after the sampling edge.
//  BUSY: mreq=1; watchdog count increments every cycle.
//   mack_n=0: capture mrdata into the granted port's data reg (reads only); mreq=0; go to RESP.
//   count==TIMEOUT with mack_n=1: mreq=0, timeout=1, data reg=0, go to RESP.
//   mack_n=0 in the same cycle as expiry counts as a normal ack; timeout unchanged.
//  RESP (exactly 1 cycle): granted ack_n=0. idt holds I-data; ddt driven with D read data.
//   Write ack: ddt stays Z. Ungranted port's ack stays 1.
//  TURN (1 cycle): requests ignored, so a stale req held through the ack cycle is not regranted; then IDLE.
//  Min latency: req sampled at edge 0 -> mreq high at 1 -> mack_n low at k>=1 -> ack_n low at k+1
//   -> next grant sampled at k+3.
//  A request arriving in BUSY/RESP/TURN waits; it is never dropped.
//  mack_n=0 while mreq=0 is ignored.
//  Upper IMEMBUS_SIZE..DMEMBUS_SIZE-1 bits of mrdata are discarded on I reads.
//  idt holds its last value between acks.
//  Fairness: with both ports continuously requesting, grants strictly alternate D,I,D,I...
// TESTING
//  T1 I read:
//   imreq=1, iad=0x100, memory acks 3 cycles after mreq with mrdata=pattern A
//   -> maddr=0x100, mwrite=0; acki_n low 1 cycle with idt=A[IMEMBUS_SIZE-1:0]; ackd_n stays 1.
//  T2 D write:
//   dmreq=1, dmwrite=1, dad=0x2000, ddt=pattern B
//   -> mwrite=1, mwdata=B, maddr=0x2000; ackd_n pulses once; ddt never driven by the block.
//  T3 tie:
//   imreq and dmreq rise in the same cycle after reset, both held through four transactions
//   -> grant order D,I,D,I; exactly 4 single-cycle ack pulses.
//  T4 back-to-back:
//   mack_n tied low (immediate ack), dmreq reasserted right after ackd_n
//   -> dmreq-sampled to ackd_n gap = 2 cycles; at least 2 idle cycles between grants (RESP+TURN).
//  T5 timeout:
//   TIMEOUT=8, memory never acks a D read
//   -> mreq falls after 8 BUSY cycles; timeout=1; ackd_n pulses with ddt=0.
//   Next transaction completes normally with timeout still 1.
//  T6 reset mid-op:
//   assert rst=0 during BUSY of an I read
//   -> mreq, outputs and state at reset values immediately (async); no acki_n pulse.
//   After rst=1, a new request completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two cache ports, the arbiter and the external memory port.
// The cache-side read/write data bus (ddt) is bidirectional and stays a plain port on the arbiter.
interface mem_bus_arbiter_if #(
  parameter int WORD_SIZE    = 32,
  parameter int IMEMBUS_SIZE = 256,
  parameter int DMEMBUS_SIZE = 256
);
  // Handshake: a cache raises its req (level) with address/data stable and holds it until its
  // active-low ack pulses for one cycle, then drops req the next cycle. The arbiter holds mreq
  // with maddr/mwrite/mwdata stable until memory pulls mack_n low; mack_n is ignored while mreq=0.
  logic [WORD_SIZE-1:0]    iad;
  logic                    imreq;
  logic [IMEMBUS_SIZE-1:0] idt;
  logic                    acki_n;
  logic [WORD_SIZE-1:0]    dad;
  logic                    dmreq;
  logic                    dmwrite;
  logic                    ackd_n;
  logic [WORD_SIZE-1:0]    maddr;
  logic                    mreq;
  logic                    mwrite;
  logic [DMEMBUS_SIZE-1:0] mwdata;
  logic [DMEMBUS_SIZE-1:0] mrdata;
  logic                    mack_n;
  logic                    timeout;

  modport master (
    input  iad, imreq, dad, dmreq, dmwrite, mrdata, mack_n,
    output idt, acki_n, ackd_n, maddr, mreq, mwrite, mwdata, timeout
  );

  modport slave (
    output iad, imreq, dad, dmreq, dmwrite, mrdata, mack_n,
    input  idt, acki_n, ackd_n, maddr, mreq, mwrite, mwdata, timeout
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Merges the I-cache refill port and the D-cache port onto one memory port, one transaction
// at a time, alternating on ties, with a watchdog that flags a memory that never acks.
module mem_bus_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int IMEMBUS_SIZE = 256,
  parameter int DMEMBUS_SIZE = 256,
  parameter int TIMEOUT      = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_bus_arbiter_if.master       bus,
  inout  wire [DMEMBUS_SIZE-1:0]  ddt,
  output logic [1:0]              dbg_state
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    TURN = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    grant_d;
  logic                    last_grant_d;
  logic [CW-1:0]           wd_cnt;
  logic [CW-1:0]           wd_inc;
  logic                    expire;
  logic                    any_req;
  logic                    pick_d;
  logic                    ddt_oe;
  logic [IMEMBUS_SIZE-1:0] idt_q;
  logic [DMEMBUS_SIZE-1:0] ddt_q;
  logic [WORD_SIZE-1:0]    maddr_q;
  logic [DMEMBUS_SIZE-1:0] mwdata_q;
  logic                    mwrite_q;
  logic                    timeout_q;

  assign any_req = bus.imreq | bus.dmreq;
  // D wins when it is alone, or on a tie when I had the previous grant.
  assign pick_d  = bus.dmreq & (~bus.imreq | ~last_grant_d);
  // wd_inc is the number of BUSY cycles completed at this edge, so mreq stays up TIMEOUT cycles.
  assign wd_inc  = wd_cnt + CW'(1);
  assign expire  = bus.mack_n & (wd_inc == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (!bus.mack_n || expire) state_nxt = RESP;
      RESP:    state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_d      <= 1'b0;
      last_grant_d <= 1'b0;
      wd_cnt       <= '0;
      idt_q        <= '0;
      ddt_q        <= '0;
      maddr_q      <= '0;
      mwdata_q     <= '0;
      mwrite_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_d      <= pick_d;
            last_grant_d <= pick_d;
            maddr_q      <= pick_d ? bus.dad : bus.iad;
            mwrite_q     <= pick_d & bus.dmwrite;
            wd_cnt       <= '0;
            if (pick_d && bus.dmwrite) mwdata_q <= ddt;
          end
        end
        BUSY: begin
          wd_cnt <= wd_inc;
          if (!bus.mack_n) begin
            if (!mwrite_q) begin
              if (grant_d) ddt_q <= bus.mrdata;
              else         idt_q <= bus.mrdata[IMEMBUS_SIZE-1:0];
            end
          end else if (expire) begin
            timeout_q <= 1'b1;
            if (grant_d) ddt_q <= '0;
            else         idt_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mreq    = (state == BUSY);
    bus.acki_n  = ~((state == RESP) & ~grant_d);
    bus.ackd_n  = ~((state == RESP) & grant_d);
    bus.idt     = idt_q;
    bus.maddr   = maddr_q;
    bus.mwrite  = mwrite_q;
    bus.mwdata  = mwdata_q;
    bus.timeout = timeout_q;
    ddt_oe      = (state == RESP) & grant_d & ~mwrite_q;
    dbg_state   = state;
  end

  assign ddt = ddt_oe ? ddt_q : {DMEMBUS_SIZE{1'bz}};
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single reads/writes, tie alternation, back-to-back,
// watchdog expiry (including ack on the expiry cycle) and asynchronous reset mid-transaction.
module tb_mem_bus_arbiter;
  localparam int WS = 32;
  localparam int IW = 128;
  localparam int DW = 256;
  localparam int TO = 8;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  wire  [DW-1:0] ddt;
  logic [DW-1:0] ddt_drv;
  logic ddt_en;

  int vectors = 0;
  int miscompares = 0;
  int cyc, mc, extra;
  int mem_mode, mem_lat, busy_cnt;

  logic [DW-1:0] pat_a, pat_b, pat_c, pat_d, pat_e;
  logic [IW-1:0] exp_idt_a, exp_idt_c;
  logic [33:0]   exp_q[$];
  logic [33:0]   exp_e;

  mem_bus_arbiter_if #(.WORD_SIZE(WS), .IMEMBUS_SIZE(IW), .DMEMBUS_SIZE(DW)) bif ();

  mem_bus_arbiter #(.WORD_SIZE(WS), .IMEMBUS_SIZE(IW), .DMEMBUS_SIZE(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .ddt       (ddt),
    .dbg_state (dbg_state)
  );

  assign ddt = ddt_en ? ddt_drv : {DW{1'bz}};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // memory model: acks mem_lat negedges after mreq is seen (mode 0), never (1), or tied low (2)
  initial begin
    bif.mack_n = 1'b1;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_mode == 2) begin
        bif.mack_n = 1'b0;
      end else if (mem_mode == 0 && bif.mreq) begin
        bif.mack_n = (busy_cnt == mem_lat) ? 1'b0 : 1'b1;
        busy_cnt++;
      end else begin
        bif.mack_n = 1'b1;
        busy_cnt = 0;
      end
    end
  end

  // driver / checker tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int n, output int m);
    n = 0;
    m = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (!bif.acki_n || !bif.ackd_n) return;
      if (bif.mreq) m++;
    end
    check("ack_wait_expired", DW'(0), DW'(1));
  endtask

  initial begin
    pat_a     = {128'hA1A2A3A4A5A6A7A8B1B2B3B4B5B6B7B8, 128'h0F1E2D3C4B5A6978DEADBEEFCAFEF00D};
    exp_idt_a = 128'h0F1E2D3C4B5A6978DEADBEEFCAFEF00D;
    pat_b     = {8{32'h5A5A0F0F}};
    pat_c     = {128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 128'h0123456789ABCDEFFEDCBA9876543210};
    exp_idt_c = 128'h0123456789ABCDEFFEDCBA9876543210;
    pat_d     = {8{32'h12345678}};
    pat_e     = {8{32'hA5A5F0F0}};

    rst = 1'b0;
    bif.iad = '0; bif.imreq = 1'b0; bif.dad = '0; bif.dmreq = 1'b0; bif.dmwrite = 1'b0;
    bif.mrdata = '0; ddt_drv = '0; ddt_en = 1'b0;
    mem_mode = 0; mem_lat = 3;
    repeat (2) tick();

    check("rst_state",   DW'(dbg_state),   DW'(2'd0));
    check("rst_acki_n",  DW'(bif.acki_n),  DW'(1'b1));
    check("rst_ackd_n",  DW'(bif.ackd_n),  DW'(1'b1));
    check("rst_mreq",    DW'(bif.mreq),    DW'(1'b0));
    check("rst_mwrite",  DW'(bif.mwrite),  DW'(1'b0));
    check("rst_maddr",   DW'(bif.maddr),   DW'(0));
    check("rst_mwdata",  bif.mwdata,       DW'(0));
    check("rst_idt",     DW'(bif.idt),     DW'(0));
    check("rst_timeout", DW'(bif.timeout), DW'(1'b0));
    rst = 1'b1;
    tick();

    // T1: I read, memory acks 3 cycles after mreq
    bif.mrdata = pat_a; bif.iad = 32'h100; bif.imreq = 1'b1;
    tick();
    check("t1_mreq",   DW'(bif.mreq),   DW'(1'b1));
    check("t1_maddr",  DW'(bif.maddr),  DW'(32'h100));
    check("t1_mwrite", DW'(bif.mwrite), DW'(1'b0));
    wait_ack(cyc, mc);
    check("t1_latency", DW'(cyc),        DW'(4));
    check("t1_acki_n",  DW'(bif.acki_n), DW'(1'b0));
    check("t1_ackd_n",  DW'(bif.ackd_n), DW'(1'b1));
    check("t1_idt",     DW'(bif.idt),    DW'(exp_idt_a));
    tick();
    check("t1_pulse",    DW'(bif.acki_n), DW'(1'b1));
    check("t1_idt_hold", DW'(bif.idt),    DW'(exp_idt_a));
    check("t1_turn",     DW'(dbg_state),  DW'(2'd3));
    bif.imreq = 1'b0;
    tick();

    // ack landing on the watchdog expiry cycle is a normal ack
    bif.mrdata = pat_e; bif.dad = 32'h2400; bif.dmwrite = 1'b0; bif.dmreq = 1'b1; mem_lat = TO - 1;
    wait_ack(cyc, mc);
    check("edge_latency",   DW'(cyc),         DW'(9));
    check("edge_mreq_cyc",  DW'(mc),          DW'(8));
    check("edge_ackd_n",    DW'(bif.ackd_n),  DW'(1'b0));
    check("edge_ddt",       ddt,              pat_e);
    check("edge_timeout",   DW'(bif.timeout), DW'(1'b0));
    tick();
    check("edge_pulse", DW'(bif.ackd_n), DW'(1'b1));
    bif.dmreq = 1'b0;
    tick();

    // T2: D write; the block must not drive ddt while the cache supplies write data
    mem_lat = 3;
    bif.dad = 32'h2000; bif.dmwrite = 1'b1; ddt_drv = pat_b; ddt_en = 1'b1; bif.dmreq = 1'b1;
    tick();
    check("t2_mreq",   DW'(bif.mreq),   DW'(1'b1));
    check("t2_mwrite", DW'(bif.mwrite), DW'(1'b1));
    check("t2_maddr",  DW'(bif.maddr),  DW'(32'h2000));
    check("t2_mwdata", bif.mwdata,      pat_b);
    wait_ack(cyc, mc);
    check("t2_latency", DW'(cyc),        DW'(4));
    check("t2_ackd_n",  DW'(bif.ackd_n), DW'(1'b0));
    check("t2_acki_n",  DW'(bif.acki_n), DW'(1'b1));
    check("t2_ddt",     ddt,             pat_b);
    tick();
    check("t2_pulse", DW'(bif.ackd_n), DW'(1'b1));
    bif.dmreq = 1'b0; bif.dmwrite = 1'b0; ddt_en = 1'b0;
    tick();

    // T5: memory never acks a D read
    mem_mode = 1; bif.dad = 32'h5000; bif.dmreq = 1'b1;
    wait_ack(cyc, mc);
    check("t5_latency",  DW'(cyc),         DW'(9));
    check("t5_mreq_cyc", DW'(mc),          DW'(8));
    check("t5_ackd_n",   DW'(bif.ackd_n),  DW'(1'b0));
    check("t5_timeout",  DW'(bif.timeout), DW'(1'b1));
    check("t5_ddt_zero", ddt,              DW'(0));
    tick();
    check("t5_pulse",  DW'(bif.ackd_n),  DW'(1'b1));
    check("t5_sticky", DW'(bif.timeout), DW'(1'b1));
    bif.dmreq = 1'b0; mem_mode = 0; mem_lat = 1;
    tick();

    bif.mrdata = pat_c; bif.iad = 32'h180; bif.imreq = 1'b1;
    wait_ack(cyc, mc);
    check("t5b_latency", DW'(cyc),         DW'(3));
    check("t5b_acki_n",  DW'(bif.acki_n),  DW'(1'b0));
    check("t5b_idt",     DW'(bif.idt),     DW'(exp_idt_c));
    check("t5b_timeout", DW'(bif.timeout), DW'(1'b1));
    tick();
    bif.imreq = 1'b0;
    tick();

    rst = 1'b0;
    #1;
    check("rst2_timeout", DW'(bif.timeout), DW'(1'b0));
    tick();
    rst = 1'b1;

    // T3: simultaneous requests right after reset, both held through four grants
    mem_lat = 0; bif.mrdata = pat_c;
    bif.dad = 32'h3000; bif.dmwrite = 1'b0; bif.iad = 32'h4000;
    exp_q.push_back({1'b1, 1'b0, 32'h3000});
    exp_q.push_back({1'b0, 1'b1, 32'h4000});
    exp_q.push_back({1'b1, 1'b0, 32'h3000});
    exp_q.push_back({1'b0, 1'b1, 32'h4000});
    bif.imreq = 1'b1; bif.dmreq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(cyc, mc);
      exp_e = exp_q.pop_front();
      check($sformatf("t3_grant%0d", k), DW'({bif.acki_n, bif.ackd_n, bif.maddr}), DW'(exp_e));
      if (exp_e[32] == 1'b0) check($sformatf("t3_ddt%0d", k), ddt, pat_c);
      else                   check($sformatf("t3_idt%0d", k), DW'(bif.idt), DW'(exp_idt_c));
      tick();
      check($sformatf("t3_pulse%0d", k), DW'({bif.acki_n, bif.ackd_n}), DW'(2'b11));
      if (k == 3) begin
        bif.imreq = 1'b0; bif.dmreq = 1'b0;
      end
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!bif.acki_n || !bif.ackd_n) extra++;
    end
    check("t3_extra_acks", DW'(extra), DW'(0));

    // T4: mack_n tied low, D request reasserted right after the ack
    mem_mode = 2; bif.mrdata = pat_d; bif.dad = 32'h6000; bif.dmreq = 1'b1;
    wait_ack(cyc, mc);
    check("t4_latency", DW'(cyc),        DW'(2));
    check("t4_ackd_n",  DW'(bif.ackd_n), DW'(1'b0));
    check("t4_ddt",     ddt,             pat_d);
    tick();
    check("t4_turn", DW'(dbg_state), DW'(2'd3));
    bif.dmreq = 1'b0;
    tick();
    check("t4_idle", DW'(dbg_state), DW'(2'd0));
    bif.dmreq = 1'b1;
    wait_ack(cyc, mc);
    check("t4_latency2", DW'(cyc),        DW'(2));
    check("t4_ackd_n2",  DW'(bif.ackd_n), DW'(1'b0));
    tick();
    bif.dmreq = 1'b0; mem_mode = 0;
    tick();

    // T6: reset asserted while an I read is in BUSY
    mem_lat = 3; bif.mrdata = pat_a; bif.iad = 32'h7000; bif.imreq = 1'b1;
    tick();
    check("t6_mreq", DW'(bif.mreq), DW'(1'b1));
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_mreq",  DW'(bif.mreq),   DW'(1'b0));
    check("t6_rst_state", DW'(dbg_state),  DW'(2'd0));
    check("t6_rst_maddr", DW'(bif.maddr),  DW'(0));
    check("t6_rst_idt",   DW'(bif.idt),    DW'(0));
    check("t6_rst_acki",  DW'(bif.acki_n), DW'(1'b1));
    bif.imreq = 1'b0;
    tick();
    rst = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!bif.acki_n || !bif.ackd_n) extra++;
    end
    check("t6_no_ack", DW'(extra), DW'(0));
    bif.iad = 32'h7040; bif.imreq = 1'b1;
    wait_ack(cyc, mc);
    check("t6_latency", DW'(cyc),        DW'(5));
    check("t6_acki_n",  DW'(bif.acki_n), DW'(1'b0));
    check("t6_maddr",   DW'(bif.maddr),  DW'(32'h7040));
    check("t6_idt",     DW'(bif.idt),    DW'(exp_idt_a));
    tick();
    bif.imreq = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
